noise_matrix_reader: RTL and testbench
======================================

NOISE_MATRIX_READER -- requirements
Module: noise_matrix_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning BRAM word and stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning BRAM word address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to stream one matrix.
REQ-006 SHALL have port size  input  3  matrix dimension code, N = 4<<size (000=4x4 ... 101=128x128).
REQ-007 SHALL have port bram_en  output  1  BRAM read enable.
REQ-008 SHALL have port bram_addr  output  ADDR_WIDTH  BRAM read word address.
REQ-009 SHALL have port bram_rdata  input  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after bram_en.
REQ-010 SHALL have port m_tdata  output  DATA_WIDTH  stream data.
REQ-011 SHALL have port m_tvalid  output  1  stream data valid.
REQ-012 SHALL have port m_tready  input  1  downstream accept.
REQ-013 SHALL have port m_tlast  output  1  marks final word of matrix.
REQ-014 SHALL have port busy  output  1  high from accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse after final word transferred.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL latch size, clear address counter to 0, go to READ next cycle; start ignored outside IDLE.
REQ-018 size 110/111 SHALL be clamped to 101 (16384 words).
REQ-019 Word count SHALL be W = N*N; addresses 0..W-1 issued in ascending order, row-major, each exactly once.
REQ-020 READ: bram_en SHALL assert only when (buffer occupancy + reads in flight) < 2; bram_addr increments after each issued read.
REQ-021 After issuing address W-1, SHALL go to DRAIN; DRAIN -> DONE when buffer empty and final word handshaken.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy low in IDLE.
REQ-023 Transfer occurs when m_tvalid & m_tready; m_tdata/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tlast SHALL be 1 only on the word from address W-1.
REQ-025 With m_tready held 1, sustained throughput SHALL be one word per cycle; first m_tvalid SHALL occur 2 cycles after the cycle start is sampled.
REQ-026 Returned data SHALL be buffered in a 2-entry skid buffer; no word dropped or duplicated under any m_tready pattern.
REQ-027 Address counter width SHALL be ADDR_WIDTH+1 so W=16384 terminates without wrap ambiguity.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, bram_en=0, bram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, buffer empty.
REQ-029 Reset mid-stream SHALL abandon the matrix; no done pulse; next start restarts at address 0.

Configuration
REQ-030 Macro NOISE_READER_ROW_LAST_EN defined SHALL add output port m_trow_last (1 bit), high on every word with column index N-1, aligned with m_tdata.
REQ-031 Without NOISE_READER_ROW_LAST_EN the port and its column counter SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package noise_pkg SHALL hold size codes, MAX_SIZE_CODE=5, state encoding, and the N/W derivation function, shared with the noise matrix filler.
REQ-033 Sub-module noise_rd_skid (2-entry valid/ready buffer, data+last[+row_last]) SHALL be instantiated once.

Verification
REQ-034 size=000, m_tready=1, BRAM preloaded addr=data -> 16 words 0..15 consecutive, tlast on word 15, done one cycle after final transfer.
REQ-035 size=001, m_tready toggled 1-0-1-0 -> 64 words in order, data stable during stalls, bram_en never exceeds 2 outstanding.
REQ-036 size=101, m_tready=1 -> 16384 words, final address 16383, tlast once, done once, no address wrap.
REQ-037 size=111 -> identical to size=101 (16384 words).
REQ-038 rst_n low at word 7 of size=000, then start size=000 -> fresh stream from address 0, no done for aborted run.
REQ-039 NOISE_READER_ROW_LAST_EN, size=000 -> m_trow_last high on words 3,7,11,15 only; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared definitions for the noise matrix reader and filler: matrix size codes,
// the FSM state encoding and the N / W derivation used to size a matrix.
package noise_pkg;

  // Matrix dimension codes: N = 4 << code
  localparam logic [2:0] SIZE_4X4     = 3'd0;
  localparam logic [2:0] SIZE_8X8     = 3'd1;
  localparam logic [2:0] SIZE_16X16   = 3'd2;
  localparam logic [2:0] SIZE_32X32   = 3'd3;
  localparam logic [2:0] SIZE_64X64   = 3'd4;
  localparam logic [2:0] SIZE_128X128 = 3'd5;
  localparam logic [2:0] MAX_SIZE_CODE = SIZE_128X128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } noise_state_e;

  // Codes above the largest matrix fold onto the largest matrix.
  function automatic logic [2:0] noise_clamp_size(input logic [2:0] code);
    return (code > MAX_SIZE_CODE) ? MAX_SIZE_CODE : code;
  endfunction

  // Matrix dimension N (4..128).
  function automatic logic [7:0] noise_dim(input logic [2:0] code);
    return 8'd4 << noise_clamp_size(code);
  endfunction

  // Word count W = N*N (16..16384).
  function automatic logic [15:0] noise_words(input logic [2:0] code);
    return 16'd16 << {noise_clamp_size(code), 1'b0};
  endfunction

endpackage

// File: rtl/noise_rd_skid.sv
// Two-entry valid/ready buffer between the BRAM read return and the output
// stream. The head entry drives the outputs directly from flops, so data and
// sideband bits stay put while the consumer stalls.
module noise_rd_skid #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop       = (count_q != 2'd0) && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

  // Push/pop bookkeeping; the producer never pushes into a full buffer
  // without a simultaneous pop because it throttles on count + in-flight reads.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({in_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy; cleared so the stream outputs read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noise_matrix_reader.sv
// Streams one N x N noise matrix out of BRAM in row-major order on a
// valid/ready stream, with tlast on the final word and a done pulse after it.
// Optional feature: define NOISE_READER_ROW_LAST_EN to add m_trow_last,
// flagging the last column of every row.
module noise_matrix_reader
  import noise_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            size,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done
`ifdef NOISE_READER_ROW_LAST_EN
  ,
  output logic                  m_trow_last
`endif
);

  // One extra address bit so that W = 2**ADDR_WIDTH still has a distinct end.
  localparam int AW1 = ADDR_WIDTH + 1;
`ifdef NOISE_READER_ROW_LAST_EN
  localparam int PW = DATA_WIDTH + 2;
`else
  localparam int PW = DATA_WIDTH + 1;
`endif

  noise_state_e   state_q, state_d;
  logic [2:0]     size_q, size_d;
  logic [AW1-1:0] addr_q, addr_d;
  logic [AW1-1:0] last_addr;
  logic           inflight_q, inflight_d;
  logic           inflight_last_q, inflight_last_d;
  logic           issue, issue_last, pop;
  logic [1:0]     occ, budget;
  logic [PW-1:0]  push_payload, head_payload;
  logic           head_valid;

`ifdef NOISE_READER_ROW_LAST_EN
  logic [6:0]     col_q, col_d;
  logic [6:0]     col_max;
  logic           inflight_row_last_q, inflight_row_last_d;
`endif

  assign last_addr = AW1'(noise_words(size_q) - 16'd1);
  assign pop       = head_valid & m_tready;

  // Words already committed to the buffer this cycle plus the read returning
  // now; the word leaving on this edge frees its slot so that a steady
  // m_tready=1 stream keeps one read issued per cycle.
  assign budget     = occ - {1'b0, pop} + {1'b0, inflight_q};
  assign issue      = (state_q == ST_READ) && (budget < 2'd2);
  assign issue_last = issue && (addr_q == last_addr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && m_tlast) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bram_en = issue;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
  end

  // Latch the matrix size and walk the read address; tag each read with
  // whether it is the final word so the tag lands with its data.
  always_comb begin
    size_d          = size_q;
    addr_d          = addr_q;
    inflight_d      = issue;
    inflight_last_d = issue_last;
    if ((state_q == ST_IDLE) && start) begin
      size_d = noise_clamp_size(size);
      addr_d = '0;
    end else if (issue) begin
      addr_d = addr_q + AW1'(1);
    end
  end

  // Address counter, latched size and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q          <= 3'd0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      size_q          <= size_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign bram_addr = addr_q[ADDR_WIDTH-1:0];

`ifdef NOISE_READER_ROW_LAST_EN
  assign col_max = 7'(noise_dim(size_q) - 8'd1);

  // Column index of the next issued read, wrapping at N-1.
  always_comb begin
    col_d               = col_q;
    inflight_row_last_d = issue && (col_q == col_max);
    if ((state_q == ST_IDLE) && start) col_d = 7'd0;
    else if (issue)                    col_d = (col_q == col_max) ? 7'd0 : col_q + 7'd1;
  end

  // Column counter and the row-end tag travelling with the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q               <= 7'd0;
      inflight_row_last_q <= 1'b0;
    end else begin
      col_q               <= col_d;
      inflight_row_last_q <= inflight_row_last_d;
    end
  end

  assign push_payload = {inflight_row_last_q, inflight_last_q, bram_rdata};
  assign m_trow_last  = head_payload[DATA_WIDTH+1];
`else
  assign push_payload = {inflight_last_q, bram_rdata};
`endif

  noise_rd_skid #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  (push_payload),
    .out_valid(head_valid),
    .out_ready(m_tready),
    .out_data (head_payload),
    .count    (occ)
  );

  assign m_tvalid = head_valid;
  assign m_tdata  = head_payload[DATA_WIDTH-1:0];
  assign m_tlast  = head_payload[DATA_WIDTH];

endmodule

// File: tb/tb_noise_matrix_reader.sv
// Directed bench for noise_matrix_reader: BRAM model returns a pattern derived
// from the address, a monitor checks every issued address and every transferred
// word, and per-run totals / timing are compared at the end of each matrix.
module tb_noise_matrix_reader;

  localparam int DW = 64;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    size = 3'd0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          busy;
  logic          done;
`ifdef NOISE_READER_ROW_LAST_EN
  logic          m_trow_last;
`endif

  always #5 clk = ~clk;

  noise_matrix_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_rdata(bram_rdata),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .done      (done)
`ifdef NOISE_READER_ROW_LAST_EN
    ,
    .m_trow_last(m_trow_last)
`endif
  );

  function automatic logic [DW-1:0] pattern(input int unsigned a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Synchronous-read BRAM: data one cycle after the enable.
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= pattern(32'(bram_addr));
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern: held high, or toggled every cycle.
  bit ready_toggle = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ready_toggle) m_tready = ~m_tready;
    else              m_tready = 1'b1;
  end

  bit            mon_en = 1'b0;
  bit            gap_chk = 1'b0;
  int            cur_words, cur_n;
  int            issue_idx, xfer_idx, tlast_cnt, done_cnt, rowl_cnt;
  int            first_valid_cyc, tlast_cyc, done_cyc, prev_xfer_cyc;
  bit            prev_stall;
  bit            pop_now;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      pop_now = m_tvalid & m_tready;
      if (prev_stall) begin
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (bram_en) begin
        chk("addr", 64'(bram_addr), 64'(issue_idx));
        chk("outstanding_le2", 64'((issue_idx + 1 - xfer_idx - int'(pop_now)) <= 2), 64'd1);
        issue_idx++;
      end
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop_now) begin
        chk("data", m_tdata, pattern(xfer_idx));
        chk("tlast", 64'(m_tlast), 64'(xfer_idx == cur_words - 1));
`ifdef NOISE_READER_ROW_LAST_EN
        chk("row_last", 64'(m_trow_last), 64'((xfer_idx % cur_n) == cur_n - 1));
        if (m_trow_last) rowl_cnt++;
`endif
        if (gap_chk && xfer_idx > 0) chk("gap", 64'(cyc - prev_xfer_cyc), 64'd1);
        prev_xfer_cyc = cyc;
        if (m_tlast) begin
          tlast_cnt++;
          tlast_cyc = cyc;
        end
        xfer_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic arm(input int words, input int n, input bit toggle);
    issue_idx       = 0;
    xfer_idx        = 0;
    tlast_cnt       = 0;
    done_cnt        = 0;
    rowl_cnt        = 0;
    first_valid_cyc = -1;
    tlast_cyc       = 0;
    done_cyc        = 0;
    prev_stall      = 1'b0;
    cur_words       = words;
    cur_n           = n;
    gap_chk         = !toggle;
    ready_toggle    = toggle;
    mon_en          = 1'b1;
  endtask

  // One matrix: pulse start, optionally poke start while busy, wait for done.
  task automatic run(input logic [2:0] sz, input int words, input int n,
                     input bit toggle, input bit poke_busy);
    int start_cyc;
    int k;
    arm(words, n, toggle);
    @(posedge clk); #1;
    start = 1'b1;
    size  = sz;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    size  = 3'd2;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (poke_busy) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      size  = 3'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < words * 3 + 50) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("words", 64'(xfer_idx), 64'(words));
    chk("issued", 64'(issue_idx), 64'(words));
    chk("tlast_cnt", 64'(tlast_cnt), 64'd1);
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("done_delay", 64'(done_cyc - tlast_cyc), 64'd1);
    chk("first_valid_lat", 64'(first_valid_cyc - (start_cyc + 1)), 64'd2);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("bram_en_idle", 64'(bram_en), 64'd0);
`ifdef NOISE_READER_ROW_LAST_EN
    chk("row_last_cnt", 64'(rowl_cnt), 64'(n));
`endif
    mon_en       = 1'b0;
    ready_toggle = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bram_en"}, 64'(bram_en), 64'd0);
    chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_tdata"}, m_tdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
`ifdef NOISE_READER_ROW_LAST_EN
    chk({tag, "_row_last"}, 64'(m_trow_last), 64'd0);
`endif
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4x4 at full rate, with a start pulse while busy that must be ignored.
    run(3'd0, 16, 4, 1'b0, 1'b1);
    // 8x8 with ready toggling every cycle.
    run(3'd1, 64, 8, 1'b1, 1'b0);
    // 16x16 with ready toggling.
    run(3'd2, 256, 16, 1'b1, 1'b0);
    // Largest matrix, and the out-of-range code that clamps onto it.
    run(3'd5, 16384, 128, 1'b0, 1'b0);
    run(3'd7, 16384, 128, 1'b0, 1'b0);

    // Abort a 4x4 at word 7 with reset, then restart from address 0.
    arm(16, 4, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    size  = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (xfer_idx < 7 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (xfer_idx < 7) chk("abort_timeout", 64'd0, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    mon_en = 1'b0;
    run(3'd0, 16, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
